// File: rtl/axi4_mem_slave_param_if.sv
// AXI4 bus bundle for the parametrised memory slave: AW/W/B write channels and AR/R read channels.
// Widths follow the slave parameters; the master modport drives requests, the slave modport answers.
interface axi4_mem_slave_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 24,
  parameter int ID_W   = 3
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arburst, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arburst, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_mem_slave_param.sv
// Parametrised AXI4 memory slave: independent write and read engines over a word-addressed RAM,
// FIXED/INCR/WRAP bursts, byte strobes, ID echo and per-beat window checking.
module axi4_mem_slave_param #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 24,
  parameter int                ID_W      = 3,
  parameter int                MEM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  axi4_mem_slave_param_if.slave s_axi
);
  localparam int                STRB_W = DATA_W / 8;
  localparam int                OFF_W  = $clog2(STRB_W);
  localparam int                IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(STRB_W);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WIN    = (ADDR_W + 1)'(MEM_DEPTH * STRB_W);
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10;

  function automatic logic burst_illegal(input logic [1:0] burst, input logic [7:0] len);
    logic ill;
    case (burst)
      BURST_FIXED, BURST_INCR: ill = 1'b0;
      BURST_WRAP: ill = !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      default:    ill = 1'b1;
    endcase
    return ill;
  endfunction

  // Illegal WRAP lengths advance like INCR; their data is discarded or flagged anyway.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [7:0] len, input logic [1:0] burst);
    logic [ADDR_W-1:0] size;
    logic [ADDR_W-1:0] nxt;
    size = ADDR_W'({1'b0, len} + 9'd1) * STEP;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_WRAP:  nxt = burst_illegal(burst, len) ? addr + STEP
                         : (addr & ~(size - ONE_A)) | ((addr + STEP) & (size - ONE_A));
      default:     nxt = addr + STEP;
    endcase
    return nxt;
  endfunction

  function automatic logic in_window(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return off < WIN;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> OFF_W);
  endfunction

  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] addr);
    return addr & ~(STEP - ONE_A);
  endfunction

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  logic [DATA_W-1:0] mem_r [MEM_DEPTH];

  w_state_t          w_state_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [7:0]        wlen_r, wcnt_r;
  logic [1:0]        wburst_r, bresp_r;
  logic              w_ill_r, w_dec_r, w_slv_r, awready_r, wready_r, bvalid_r;
  logic [ID_W-1:0]   bid_r;
  logic              w_hs_s, w_in_s, w_last_s, w_dec_s, w_slv_s, w_we_s;
  logic [IDX_W-1:0]  w_idx_s;

  r_state_t          r_state_r;
  logic [ADDR_W-1:0] raddr_r;
  logic [7:0]        rlen_r, rcnt_r;
  logic [1:0]        rburst_r, rresp_r;
  logic              r_ill_r, arready_r, rvalid_r, rlast_r;
  logic [ID_W-1:0]   rid_r;
  logic [DATA_W-1:0] rdata_r;
  logic [ADDR_W-1:0] f_addr_s;
  logic              f_ill_s, f_in_s;
  logic [DATA_W-1:0] f_data_s;
  logic [1:0]        f_resp_s;

  // Per-beat write decode: range, end-of-burst, accumulated error flags.
  always_comb begin
    w_hs_s   = s_axi.wvalid & wready_r;
    w_in_s   = in_window(waddr_r);
    w_idx_s  = word_idx(waddr_r);
    w_last_s = (wcnt_r == wlen_r);
    w_dec_s  = w_dec_r | ~w_in_s;
    w_slv_s  = w_slv_r | (s_axi.wlast != w_last_s);
    w_we_s   = w_hs_s & w_in_s & ~w_ill_r;
  end

  // Write engine: accept AW, consume len+1 W beats, then hold B until accepted.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= {ID_W{1'b0}};
      bresp_r   <= RESP_OKAY;
      waddr_r   <= {ADDR_W{1'b0}};
      wlen_r    <= 8'd0;
      wcnt_r    <= 8'd0;
      wburst_r  <= BURST_FIXED;
      w_ill_r   <= 1'b0;
      w_dec_r   <= 1'b0;
      w_slv_r   <= 1'b0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (s_axi.awvalid && awready_r) begin
            bid_r     <= s_axi.awid;
            waddr_r   <= align(s_axi.awaddr);
            wlen_r    <= s_axi.awlen;
            wburst_r  <= s_axi.awburst;
            wcnt_r    <= 8'd0;
            w_ill_r   <= burst_illegal(s_axi.awburst, s_axi.awlen);
            w_slv_r   <= burst_illegal(s_axi.awburst, s_axi.awlen);
            w_dec_r   <= 1'b0;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            w_state_r <= W_DATA;
          end else begin
            awready_r <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            waddr_r <= next_addr(waddr_r, wlen_r, wburst_r);
            wcnt_r  <= wcnt_r + 8'd1;
            w_dec_r <= w_dec_s;
            w_slv_r <= w_slv_s;
            if (w_last_s) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              bresp_r   <= w_dec_s ? RESP_DECERR : (w_slv_s ? RESP_SLVERR : RESP_OKAY);
              w_state_r <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: w_state_r <= W_IDLE;
      endcase
    end
  end

  // RAM write port with byte enables; contents survive reset.
  always_ff @(posedge s_axi_aclk) begin
    if (w_we_s) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem_r[w_idx_s][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // Read fetch: beat 0 comes straight from AR, later beats from the advanced address.
  always_comb begin
    f_addr_s = (r_state_r == R_IDLE) ? align(s_axi.araddr) : raddr_r;
    f_ill_s  = (r_state_r == R_IDLE) ? burst_illegal(s_axi.arburst, s_axi.arlen) : r_ill_r;
    f_in_s   = in_window(f_addr_s);
    f_data_s = f_in_s ? mem_r[word_idx(f_addr_s)] : {DATA_W{1'b0}};
    f_resp_s = !f_in_s ? RESP_DECERR : (f_ill_s ? RESP_SLVERR : RESP_OKAY);
  end

  // Read engine: registered R beat, next beat loaded on the same edge as each handshake.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rid_r     <= {ID_W{1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      rresp_r   <= RESP_OKAY;
      rlast_r   <= 1'b0;
      raddr_r   <= {ADDR_W{1'b0}};
      rlen_r    <= 8'd0;
      rcnt_r    <= 8'd0;
      rburst_r  <= BURST_FIXED;
      r_ill_r   <= 1'b0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (s_axi.arvalid && arready_r) begin
            rid_r     <= s_axi.arid;
            rlen_r    <= s_axi.arlen;
            rburst_r  <= s_axi.arburst;
            r_ill_r   <= f_ill_s;
            rcnt_r    <= 8'd0;
            rdata_r   <= f_data_s;
            rresp_r   <= f_resp_s;
            rlast_r   <= (s_axi.arlen == 8'd0);
            raddr_r   <= next_addr(f_addr_s, s_axi.arlen, s_axi.arburst);
            arready_r <= 1'b0;
            rvalid_r  <= 1'b1;
            r_state_r <= R_DATA;
          end else begin
            arready_r <= 1'b1;
          end
        end
        R_DATA: begin
          if (rvalid_r && s_axi.rready) begin
            if (rlast_r) begin
              rvalid_r  <= 1'b0;
              rlast_r   <= 1'b0;
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end else begin
              rcnt_r  <= rcnt_r + 8'd1;
              rdata_r <= f_data_s;
              rresp_r <= f_resp_s;
              rlast_r <= ((rcnt_r + 8'd1) == rlen_r);
              raddr_r <= next_addr(raddr_r, rlen_r, rburst_r);
            end
          end
        end
        default: r_state_r <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_r;
  assign s_axi.wready  = wready_r;
  assign s_axi.bid     = bid_r;
  assign s_axi.bresp   = bresp_r;
  assign s_axi.bvalid  = bvalid_r;
  assign s_axi.arready = arready_r;
  assign s_axi.rid     = rid_r;
  assign s_axi.rdata   = rdata_r;
  assign s_axi.rresp   = rresp_r;
  assign s_axi.rlast   = rlast_r;
  assign s_axi.rvalid  = rvalid_r;
endmodule
